rst_controller_mc: RTL and testbench
====================================

Name: rst_controller_mc

Overview:
- Next-generation multi-domain reset controller.
- Drives N_DOM independent active-high reset domains with hold stretching and staggered, ordered release.
- Triggers system reset from software or on SoC fault, records the reset cause and fault details in sticky registers.
- Sits behind the peripheral bus as a slave in the integration layer, replacing the single-output controller.

Parameters:
- N_DOM, 4, number of reset domains (1..8); domain 0 released first.
- HOLD_CYC, 16, cycles all domains stay asserted after any reset trigger (>=1).
- STAGGER, 4, cycles between release of domain i and domain i+1 (>=1).
- ADDR_W, 4, byte-address width of the register window.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset; resets the whole block including sticky registers.
- addr  in  ADDR_W  byte address.
- w_rb  in  1  1=write, 0=read.
- acc  in  $clog2(`BUS_ACC_CNT)  access size: 0=byte, 1=half, 2=word.
- wdata  in  `BUS_WIDTH  write data.
- rdata  out  `BUS_WIDTH  read data.
- req  in  1  access request, single-cycle pulse.
- resp  out  1  access response, single-cycle pulse.
- fault  out  1  bus error, valid with resp.
- soc_fault  in  1  SoC fault strobe.
- soc_fault_cause  in  8  fault cause code.
- soc_fault_addr  in  `XLEN  faulting address.
- rst_o  out  N_DOM  per-domain reset, active-high, deasserts synchronously to clk.

Behaviour:
- Reset values (rst high):
  - rst_o = all 1; resp = 0; fault = 0; rdata = 0.
  - CAUSE = 0 (POR); FADDR = 0; HOLD bits = 0; FSM = HOLD, counter = HOLD_CYC-1.
- FSM:
  - HOLD: all rst_o = 1; counter decrements; at 0 go to REL with domain index 0.
  - REL: clear rst_o[idx] unless HOLD[idx]=1; wait STAGGER cycles; idx++; after N_DOM-1 go to RUN.
  - RUN: steady state.
- Triggers (valid in RUN only; ignored in HOLD/REL):
  - SW: write of 1 to CTRL[0].
  - FAULT: soc_fault=1.
  - Either trigger sets all rst_o=1 next cycle, reloads the counter and enters HOLD.
- Simultaneous SW and FAULT in the same cycle: FAULT wins.
- CAUSE register:
  - [1:0] = 0 POR, 1 SW, 2 FAULT, 3 WDT.
  - [15:8] = fault cause (updated on FAULT only).
  - Sticky; cleared only by rst.
- FADDR: latched from soc_fault_addr on an accepted FAULT.
- Domain hold bits (CTRL[8+N_DOM-1:8], read/write):
  - Setting a bit in RUN asserts that domain's rst_o on the next cycle.
  - Clearing the bit deasserts it next cycle.
  - Hold bits are not cleared by SW or FAULT resets.
- Register map:
  - 0x0 CTRL: bit0 write-only, reads 0.
  - 0x4 CAUSE: read-only.
  - 0x8 FADDR: read-only.
  - 0xC WDT: see Optional Feature.
- Bus timing:
  - resp asserts exactly 1 cycle after req.
  - rdata is valid with resp and 0 otherwise.
- Bus faults: non-word acc, addr[1:0]≠0, write to a read-only register, or unmapped address.
  - Response: resp=1 with fault=1; no state change; rdata=0.
- The bus interface keeps operating during HOLD/REL, because the controller is not reset by rst_o.

Optional Feature:
- Macro: RST_WDT_EN.
- With RST_WDT_EN:
  - 0xC WDT is read/write, 32-bit reload value; write 0 disables the watchdog.
  - Any write reloads the counter.
  - In RUN, the counter decrements each cycle; on reaching 0 it triggers reset with CAUSE=3.
  - Priority: FAULT > WDT > SW.
  - The counter is reloaded and paused during HOLD/REL.
- Without RST_WDT_EN: any access to 0xC faults; no counter logic is synthesized.

Decomposition:
- Shared package/header femto.vh additions:
  - RST cause codes (POR/SW/FAULT/WDT).
  - Register offsets.
  - Access-size encodings.
  - RST_SIZE updated to 16.
- One sub-module: rst_release_seq.
  - Contains the HOLD/REL/RUN FSM, hold counter, stagger counter and domain index.
  - Outputs a per-domain release mask; the top module ORs in the hold bits.

Test Plan:
- rst pulse, N_DOM=4, HOLD_CYC=16, STAGGER=4 -> rst_o=4'hF for 16 cycles after rst falls, then bits clear in order 0,1,2,3 at 4-cycle spacing; CAUSE reads 0.
- In RUN, write 0x1 to 0x0 -> rst_o=4'hF next cycle, release sequence repeats; CAUSE reads 0x1.
- soc_fault with cause 0x5A and addr 0x8000_1234, same cycle as SW write -> CAUSE=0x5A02, FADDR=0x8000_1234.
- Write CTRL=0x0200 in RUN -> rst_o[1]=1 only; after a SW reset, rst_o[1] stays 1 while the other domains release.
- Byte read at 0x4, word read at 0x6, write to 0x4 -> each returns resp=1, fault=1 one cycle after req, rdata=0.
- RST_WDT_EN: write WDT=100 -> reset fires 100 cycles later, CAUSE[1:0]=3; with the macro undefined, access to 0xC faults.

Source files
------------

// File: rtl/rst_controller_mc_pkg.sv
// Shared definitions for the multi-domain reset controller: cause codes,
// register offsets, access-size encodings and release-sequencer states.
package rst_controller_mc_pkg;

    localparam int XLEN        = 32;
    localparam int BUS_W       = 32;
    localparam int BUS_ACC_CNT = 3;
    localparam int ACC_W       = $clog2(BUS_ACC_CNT);
    localparam int RST_SIZE    = 16;

    typedef enum logic [1:0] {
        CAUSE_POR   = 2'd0,
        CAUSE_SW    = 2'd1,
        CAUSE_FAULT = 2'd2,
        CAUSE_WDT   = 2'd3
    } rst_cause_e;

    typedef enum logic [ACC_W-1:0] {
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_size_e;

    localparam logic [31:0] OFF_CTRL  = 32'h0;
    localparam logic [31:0] OFF_CAUSE = 32'h4;
    localparam logic [31:0] OFF_FADDR = 32'h8;
    localparam logic [31:0] OFF_WDT   = 32'hC;

    localparam int CTRL_HOLD_LSB = 8;

    typedef enum logic [1:0] {
        SEQ_HOLD,
        SEQ_REL,
        SEQ_RUN
    } seq_state_e;

endpackage

// File: rtl/rst_controller_mc_release_seq.sv
// Hold/stagger release sequencer: produces the mask of released domains,
// domain 0 first, and accepts a new reset trigger only once fully running.
module rst_release_seq
    import rst_controller_mc_pkg::*;
#(
    parameter int N_DOM    = 4,
    parameter int HOLD_CYC = 16,
    parameter int STAGGER  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    output logic [N_DOM-1:0] released,
    output logic             running
);

    localparam int CNT_MAX = (HOLD_CYC > STAGGER) ? HOLD_CYC : STAGGER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    seq_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n, idx_inc;
    logic [N_DOM-1:0] rel_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEQ_HOLD;
            cnt      <= CNT_W'(HOLD_CYC - 1);
            idx      <= '0;
            released <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            released <= rel_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        rel_n   = released;
        idx_inc = idx + IDX_W'(1);
        case (state)
            SEQ_HOLD: begin
                rel_n = '0;
                if (cnt == '0) begin
                    rel_n[0] = 1'b1;
                    idx_n    = '0;
                    cnt_n    = CNT_W'(STAGGER - 1);
                    state_n  = (N_DOM == 1) ? SEQ_RUN : SEQ_REL;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            SEQ_REL: begin
                // Releasing the last domain is what makes the block RUN.
                if (cnt == '0) begin
                    idx_n          = idx_inc;
                    rel_n[idx_inc] = 1'b1;
                    cnt_n          = CNT_W'(STAGGER - 1);
                    if (idx_inc == IDX_W'(N_DOM - 1)) state_n = SEQ_RUN;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            SEQ_RUN: begin
                if (trig) begin
                    state_n = SEQ_HOLD;
                    cnt_n   = CNT_W'(HOLD_CYC - 1);
                    rel_n   = '0;
                end
            end
            default: state_n = SEQ_HOLD;
        endcase
    end

    assign running = (state == SEQ_RUN);

endmodule

// File: rtl/rst_controller_mc.sv
// Multi-domain reset controller with bus register window and sticky cause log.
// Optional watchdog at 0xC is built only when RST_WDT_EN is defined.
module rst_controller_mc
    import rst_controller_mc_pkg::*;
#(
    parameter int N_DOM    = 4,
    parameter int HOLD_CYC = 16,
    parameter int STAGGER  = 4,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              w_rb,
    input  logic [ACC_W-1:0]  acc,
    input  logic [BUS_W-1:0]  wdata,
    output logic [BUS_W-1:0]  rdata,
    input  logic              req,
    output logic              resp,
    output logic              fault,
    input  logic              soc_fault,
    input  logic [7:0]        soc_fault_cause,
    input  logic [XLEN-1:0]   soc_fault_addr,
    output logic [N_DOM-1:0]  rst_o
);

    logic [31:0]         addr_ext;
    logic                sel_ctrl, sel_cause, sel_faddr, sel_wdt;
    logic                bus_err, wr_ok, sw_req;
    logic                fault_trig, wdt_trig, sw_trig, trig, wdt_expire;
    logic [BUS_W-1:0]    rd_val;
    logic [N_DOM-1:0]    hold_bits, released;
    logic                running;
    logic [RST_SIZE-1:0] cause;
    logic [XLEN-1:0]     faddr;

`ifdef RST_WDT_EN
    logic [31:0] wdt_reload, wdt_cnt;
`endif

    assign addr_ext = 32'(addr);

    always_comb begin
        sel_ctrl  = (addr_ext == OFF_CTRL);
        sel_cause = (addr_ext == OFF_CAUSE);
        sel_faddr = (addr_ext == OFF_FADDR);
        sel_wdt   = 1'b0;
`ifdef RST_WDT_EN
        sel_wdt   = (addr_ext == OFF_WDT);
`endif
        bus_err = (acc != ACC_WORD) || (addr[1:0] != 2'b00) ||
                  !(sel_ctrl || sel_cause || sel_faddr || sel_wdt) ||
                  (w_rb && (sel_cause || sel_faddr));
        rd_val = '0;
        if (sel_ctrl)       rd_val[CTRL_HOLD_LSB +: N_DOM] = hold_bits;
        else if (sel_cause) rd_val = BUS_W'(cause);
        else if (sel_faddr) rd_val = BUS_W'(faddr);
`ifdef RST_WDT_EN
        else if (sel_wdt)   rd_val = wdt_reload;
`endif
    end

    // Triggers are honoured only in RUN; priority FAULT > WDT > SW.
    assign wr_ok      = req && w_rb && !bus_err;
    assign sw_req     = wr_ok && sel_ctrl && wdata[0];
    assign fault_trig = running && soc_fault;
    assign wdt_trig   = running && !soc_fault && wdt_expire;
    assign sw_trig    = running && !soc_fault && !wdt_expire && sw_req;
    assign trig       = fault_trig || wdt_trig || sw_trig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp      <= 1'b0;
            fault     <= 1'b0;
            rdata     <= '0;
            hold_bits <= '0;
            cause     <= '0;
            faddr     <= '0;
        end else begin
            resp  <= req;
            fault <= req && bus_err;
            rdata <= (req && !w_rb && !bus_err) ? rd_val : '0;
            if (wr_ok && sel_ctrl) hold_bits <= wdata[CTRL_HOLD_LSB +: N_DOM];
            if (fault_trig) begin
                cause <= {soc_fault_cause, 6'b0, CAUSE_FAULT};
                faddr <= soc_fault_addr;
            end else if (wdt_trig) begin
                cause[1:0] <= CAUSE_WDT;
            end else if (sw_trig) begin
                cause[1:0] <= CAUSE_SW;
            end
        end
    end

`ifdef RST_WDT_EN
    // Counter fires on the cycle it would step from 1 to 0; frozen at reload outside RUN.
    assign wdt_expire = running && (wdt_reload != '0) && (wdt_cnt == 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_reload <= '0;
            wdt_cnt    <= '0;
        end else if (wr_ok && sel_wdt) begin
            wdt_reload <= wdata;
            wdt_cnt    <= wdata;
        end else if (!running || trig) begin
            wdt_cnt <= wdt_reload;
        end else if (wdt_reload != '0) begin
            wdt_cnt <= wdt_cnt - 32'd1;
        end
    end
`else
    logic unused_wdata;
    assign wdt_expire   = 1'b0;
    assign unused_wdata = ^wdata;
`endif

    rst_release_seq #(
        .N_DOM    (N_DOM),
        .HOLD_CYC (HOLD_CYC),
        .STAGGER  (STAGGER)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .trig     (trig),
        .released (released),
        .running  (running)
    );

    assign rst_o = ~released | hold_bits;

endmodule

// File: tb/tb_rst_controller_mc.sv
// Bench for rst_controller_mc: table-driven bus vectors, directed reset
// sequences and randomized traffic against an elapsed-time reference model.
module tb_rst_controller_mc;
    import rst_controller_mc_pkg::*;

    localparam int N_DOM    = 4;
    localparam int HOLD_CYC = 16;
    localparam int STAGGER  = 4;
    localparam int ADDR_W   = 4;
    localparam int RUN_K    = HOLD_CYC + (N_DOM - 1) * STAGGER;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic              w_rb;
    logic [ACC_W-1:0]  acc;
    logic [BUS_W-1:0]  wdata, rdata;
    logic              req, resp, fault;
    logic              soc_fault;
    logic [7:0]        soc_fault_cause;
    logic [XLEN-1:0]   soc_fault_addr;
    logic [N_DOM-1:0]  rst_o;

    rst_controller_mc #(
        .N_DOM(N_DOM), .HOLD_CYC(HOLD_CYC), .STAGGER(STAGGER), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .w_rb(w_rb), .acc(acc),
        .wdata(wdata), .rdata(rdata), .req(req), .resp(resp), .fault(fault),
        .soc_fault(soc_fault), .soc_fault_cause(soc_fault_cause),
        .soc_fault_addr(soc_fault_addr), .rst_o(rst_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: k counts edges since the last reset trigger.
    int               k;
    logic [N_DOM-1:0] m_hold;
    logic [15:0]      m_cause;
    logic [31:0]      m_faddr;
    logic             m_resp, m_fault;
    logic [31:0]      m_rdata;
`ifdef RST_WDT_EN
    longint           n_edge = 0;
    longint           m_wdt_deadline;
    logic [31:0]      m_wdt_reload;
`endif

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sz;
        logic [3:0]  a;
        logic [31:0] d;
        logic        exp_fault;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl[$];

    logic [31:0] rd;
    logic        flt, rs;

    function automatic logic m_running(int kk);
        return kk >= RUN_K;
    endfunction

    function automatic logic [N_DOM-1:0] m_rst_o();
        logic [N_DOM-1:0] r;
        for (int i = 0; i < N_DOM; i++) r[i] = (k < HOLD_CYC + i * STAGGER) || m_hold[i];
        return r;
    endfunction

    function automatic logic m_bus_err(logic w, logic [1:0] sz, logic [ADDR_W-1:0] a);
        logic ok_addr;
        ok_addr = (a == 4'h0) || (a == 4'h4) || (a == 4'h8);
`ifdef RST_WDT_EN
        ok_addr = ok_addr || (a == 4'hC);
`endif
        return (sz != 2'd2) || !ok_addr || (w && (a == 4'h4 || a == 4'h8));
    endfunction

    function automatic logic [31:0] m_read(logic [ADDR_W-1:0] a);
        case (a)
            4'h0: return 32'(m_hold) << 8;
            4'h4: return {16'h0, m_cause};
            4'h8: return m_faddr;
`ifdef RST_WDT_EN
            4'hC: return m_wdt_reload;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic run_pre, err, wr_ok, trig_f, trig_w, trig_s;
        run_pre = m_running(k);
        err     = m_bus_err(w_rb, acc, addr);
        wr_ok   = req && w_rb && !err;
        trig_f  = run_pre && soc_fault;
        trig_w  = 1'b0;
`ifdef RST_WDT_EN
        trig_w  = run_pre && !trig_f && (m_wdt_reload != 0) && (n_edge + 1 == m_wdt_deadline);
`endif
        trig_s  = run_pre && !trig_f && !trig_w && wr_ok && (addr == 4'h0) && wdata[0];
        m_resp  = req;
        m_fault = req && err;
        m_rdata = (req && !w_rb && !err) ? m_read(addr) : 32'h0;
        @(posedge clk);
        if (wr_ok && addr == 4'h0) m_hold = wdata[8 +: N_DOM];
        if (trig_f) begin
            m_cause = {soc_fault_cause, 8'h02};
            m_faddr = soc_fault_addr;
        end else if (trig_w) m_cause[1:0] = 2'd3;
        else if (trig_s) m_cause[1:0] = 2'd1;
        k = (trig_f || trig_w || trig_s) ? 0 : k + 1;
`ifdef RST_WDT_EN
        n_edge++;
        if (wr_ok && addr == 4'hC) begin
            m_wdt_reload = wdata;
            if (run_pre) m_wdt_deadline = n_edge + longint'(wdata);
        end
        if (m_running(k) && !run_pre) m_wdt_deadline = n_edge + longint'(m_wdt_reload);
`endif
        #1;
        check("rst_o", 32'(rst_o), 32'(m_rst_o()));
        check("resp",  32'(resp),  32'(m_resp));
        check("fault", 32'(fault), 32'(m_fault));
        check("rdata", rdata, m_rdata);
    endtask

    task automatic bus(input logic w, input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                       input logic [31:0] d, output logic [31:0] rdv, output logic f,
                       output logic r);
        req = 1'b1; w_rb = w; acc = sz; addr = a; wdata = d;
        tick();
        rdv = rdata; f = fault; r = resp;
        req = 1'b0; w_rb = 1'b0; acc = 2'd2; addr = '0; wdata = '0;
    endtask

    task automatic do_reset();
        req = 1'b0; w_rb = 1'b0; acc = 2'd2; addr = '0; wdata = '0;
        soc_fault = 1'b0; soc_fault_cause = '0; soc_fault_addr = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_rst_o", 32'(rst_o), 32'hF);
        check("rst_resp",  32'(resp),  32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        k = 0; m_hold = '0; m_cause = '0; m_faddr = '0;
`ifdef RST_WDT_EN
        m_wdt_reload = '0; m_wdt_deadline = -1;
`endif
    endtask

    task automatic wait_run();
        for (int i = 0; i < RUN_K + 2; i++) tick();
    endtask

    initial begin
        tbl.push_back('{"rd_ctrl",      1'b0, 2'd2, 4'h0, 32'h0,    1'b0, 32'h0});
        tbl.push_back('{"rd_cause",     1'b0, 2'd2, 4'h4, 32'h0,    1'b0, 32'h0});
        tbl.push_back('{"rd_faddr",     1'b0, 2'd2, 4'h8, 32'h0,    1'b0, 32'h0});
        tbl.push_back('{"rd_byte_4",    1'b0, 2'd0, 4'h4, 32'h0,    1'b1, 32'h0});
        tbl.push_back('{"rd_word_6",    1'b0, 2'd2, 4'h6, 32'h0,    1'b1, 32'h0});
        tbl.push_back('{"wr_cause",     1'b1, 2'd2, 4'h4, 32'hFFFF, 1'b1, 32'h0});
        tbl.push_back('{"wr_faddr",     1'b1, 2'd2, 4'h8, 32'h1,    1'b1, 32'h0});
        tbl.push_back('{"rd_half_0",    1'b0, 2'd1, 4'h0, 32'h0,    1'b1, 32'h0});
        tbl.push_back('{"rd_acc3",      1'b0, 2'd3, 4'h0, 32'h0,    1'b1, 32'h0});
        tbl.push_back('{"wr_byte_ctrl", 1'b1, 2'd0, 4'h0, 32'h1,    1'b1, 32'h0});
        tbl.push_back('{"wr_ctrl_hold", 1'b1, 2'd2, 4'h0, 32'h300,  1'b0, 32'h0});
        tbl.push_back('{"rd_ctrl_hold", 1'b0, 2'd2, 4'h0, 32'h0,    1'b0, 32'h300});
        tbl.push_back('{"wr_ctrl_clr",  1'b1, 2'd2, 4'h0, 32'h0,    1'b0, 32'h0});
`ifdef RST_WDT_EN
        tbl.push_back('{"rd_wdt",       1'b0, 2'd2, 4'hC, 32'h0,    1'b0, 32'h0});
        tbl.push_back('{"wr_wdt",       1'b1, 2'd2, 4'hC, 32'h0,    1'b0, 32'h0});
`else
        tbl.push_back('{"rd_wdt",       1'b0, 2'd2, 4'hC, 32'h0,    1'b1, 32'h0});
        tbl.push_back('{"wr_wdt",       1'b1, 2'd2, 4'hC, 32'h0,    1'b1, 32'h0});
`endif

        do_reset();

        // Power-on release: 16 cycles all asserted, then 0,1,2,3 at 4-cycle spacing.
        for (int t = 1; t <= RUN_K + 1; t++) begin
            tick();
            if (t == HOLD_CYC - 1)           check("por_hold", 32'(rst_o), 32'hF);
            if (t == HOLD_CYC)               check("por_rel0", 32'(rst_o), 32'hE);
            if (t == HOLD_CYC + STAGGER - 1) check("por_gap",  32'(rst_o), 32'hE);
            if (t == HOLD_CYC + STAGGER)     check("por_rel1", 32'(rst_o), 32'hC);
            if (t == HOLD_CYC + 2 * STAGGER) check("por_rel2", 32'(rst_o), 32'h8);
            if (t == HOLD_CYC + 3 * STAGGER) check("por_rel3", 32'(rst_o), 32'h0);
        end

        foreach (tbl[i]) begin
            bus(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, rd, flt, rs);
            check($sformatf("%s_resp", tbl[i].name),  32'(rs),  32'h1);
            check($sformatf("%s_fault", tbl[i].name), 32'(flt), 32'(tbl[i].exp_fault));
            check($sformatf("%s_rdata", tbl[i].name), rd, tbl[i].exp_rd);
        end

        // Software reset.
        bus(1'b1, 2'd2, 4'h0, 32'h1, rd, flt, rs);
        check("sw_assert", 32'(rst_o), 32'hF);
        wait_run();
        bus(1'b0, 2'd2, 4'h4, 32'h0, rd, flt, rs);
        check("sw_cause", rd, 32'h1);

        // Fault and software reset in the same cycle.
        soc_fault = 1'b1; soc_fault_cause = 8'h5A; soc_fault_addr = 32'h8000_1234;
        bus(1'b1, 2'd2, 4'h0, 32'h1, rd, flt, rs);
        soc_fault = 1'b0;
        check("flt_assert", 32'(rst_o), 32'hF);
        wait_run();
        bus(1'b0, 2'd2, 4'h4, 32'h0, rd, flt, rs);
        check("flt_cause", rd, 32'h5A02);
        bus(1'b0, 2'd2, 4'h8, 32'h0, rd, flt, rs);
        check("flt_faddr", rd, 32'h8000_1234);

        // Domain hold bit survives a SW reset; a fault during HOLD is ignored.
        bus(1'b1, 2'd2, 4'h0, 32'h200, rd, flt, rs);
        check("hold_assert", 32'(rst_o), 32'h2);
        bus(1'b1, 2'd2, 4'h0, 32'h201, rd, flt, rs);
        check("hold_sw", 32'(rst_o), 32'hF);
        soc_fault = 1'b1; soc_fault_cause = 8'h33; soc_fault_addr = 32'hDEAD_0000;
        tick();
        soc_fault = 1'b0;
        wait_run();
        check("hold_kept", 32'(rst_o), 32'h2);
        bus(1'b0, 2'd2, 4'h4, 32'h0, rd, flt, rs);
        check("hold_cause", rd, 32'h5A01);
        bus(1'b1, 2'd2, 4'h0, 32'h0, rd, flt, rs);
        check("hold_clear", 32'(rst_o), 32'h0);

`ifdef RST_WDT_EN
        begin
            int fired_at;
            fired_at = 0;
            bus(1'b1, 2'd2, 4'hC, 32'd100, rd, flt, rs);
            for (int i = 1; i <= 200; i++) begin
                tick();
                if (rst_o == 4'hF) begin
                    fired_at = i;
                    break;
                end
            end
            check("wdt_delay", 32'(fired_at), 32'd100);
            bus(1'b0, 2'd2, 4'h4, 32'h0, rd, flt, rs);
            check("wdt_cause", rd, 32'h5A03);
            bus(1'b1, 2'd2, 4'hC, 32'h0, rd, flt, rs);
            wait_run();
        end
`endif

        // Randomized traffic, model-checked every cycle.
        for (int c = 0; c < 1500; c++) begin
            soc_fault       = ($urandom_range(0, 79) == 0);
            soc_fault_cause = 8'($urandom);
            soc_fault_addr  = $urandom;
            req             = ($urandom_range(0, 99) < 40);
            w_rb            = 1'($urandom_range(0, 1));
            acc             = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            case ($urandom_range(0, 4))
                0:       addr = 4'h0;
                1:       addr = 4'h4;
                2:       addr = 4'h8;
                3:       addr = 4'hC;
                default: addr = 4'($urandom);
            endcase
            wdata = $urandom;
            if (addr == 4'h0) wdata[0] = ($urandom_range(0, 9) == 0);
`ifdef RST_WDT_EN
            if (addr == 4'hC) wdata = 32'($urandom_range(0, 300));
`endif
            tick();
        end
        req = 1'b0; soc_fault = 1'b0;
        tick();

        // Asynchronous reset clears sticky state.
        do_reset();
        bus(1'b0, 2'd2, 4'h4, 32'h0, rd, flt, rs);
        check("rst_cause", rd, 32'h0);
        bus(1'b0, 2'd2, 4'h8, 32'h0, rd, flt, rs);
        check("rst_faddr", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
